// File: rtl/card_match_checker.sv
// Pair-matching stage for the memory game: latches the shuffled card array, takes two selections
// per turn, marks matched pairs, holds mismatches face-up for SHOW_CYCLES, and flags the win.
module card_match_checker #(
  parameter int unsigned SHOW_CYCLES = 50_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [15:0][4:0] arr_in_i,
  input  logic             sel_valid_i,
  input  logic [3:0]       sel_idx_i,
  output logic [15:0][4:0] arr_out_o,
  output logic [15:0]      revealed_o,
  output logic             busy_o,
  output logic             match_p_o,
  output logic             miss_p_o,
  output logic             sel_err_o,
  output logic [3:0]       pairs_o,
  output logic             win_o
);

  localparam int unsigned CntW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CntW-1:0] ShowLoad = CntW'(SHOW_CYCLES - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFirst   = 3'd1;
  localparam logic [2:0] StSecond  = 3'd2;
  localparam logic [2:0] StCompare = 3'd3;
  localparam logic [2:0] StShow    = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [15:0][4:0] arr_q, arr_d;
  logic [15:0]      rev_q, rev_d;
  logic [3:0]       idx_a_q, idx_a_d;
  logic [3:0]       idx_b_q, idx_b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       pairs_q, pairs_d;
  logic             match_q, match_d;
  logic             miss_q, miss_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             win_q, win_d;

  // Bit 4 of the incoming words is dropped on load; the matched flag always starts clear.
  logic [15:0] unused_in_flag;
  for (genvar g = 0; g < 16; g++) begin : gen_unused
    assign unused_in_flag[g] = arr_in_i[g][4];
  end

  always_comb begin
    state_d = state_q;
    arr_d   = arr_q;
    rev_d   = rev_q;
    idx_a_d = idx_a_q;
    idx_b_d = idx_b_q;
    cnt_d   = cnt_q;
    pairs_d = pairs_q;
    match_d = 1'b0;
    miss_d  = 1'b0;
    err_d   = 1'b0;

    if (load_i) begin
      for (int i = 0; i < 16; i++) begin
        arr_d[i] = {1'b0, arr_in_i[i][3:0]};
      end
      rev_d   = '0;
      pairs_d = '0;
      cnt_d   = '0;
      state_d = StFirst;
    end else begin
      case (state_q)
        StFirst: begin
          if (sel_valid_i) begin
            if (arr_q[sel_idx_i][4]) begin
              err_d = 1'b1;
            end else begin
              idx_a_d          = sel_idx_i;
              rev_d[sel_idx_i] = 1'b1;
              state_d          = StSecond;
            end
          end
        end
        StSecond: begin
          if (sel_valid_i) begin
            if (arr_q[sel_idx_i][4] || (sel_idx_i == idx_a_q)) begin
              err_d = 1'b1;
            end else begin
              idx_b_d          = sel_idx_i;
              rev_d[sel_idx_i] = 1'b1;
              state_d          = StCompare;
            end
          end
        end
        StCompare: begin
          if (arr_q[idx_a_q][3:0] == arr_q[idx_b_q][3:0]) begin
            arr_d[idx_a_q][4] = 1'b1;
            arr_d[idx_b_q][4] = 1'b1;
            rev_d[idx_a_q]    = 1'b0;
            rev_d[idx_b_q]    = 1'b0;
            pairs_d           = pairs_q + 4'd1;
            match_d           = 1'b1;
            state_d           = (pairs_q == 4'd7) ? StDone : StFirst;
          end else begin
            cnt_d   = ShowLoad;
            state_d = StShow;
          end
        end
        StShow: begin
          if (cnt_q == '0) begin
            rev_d[idx_a_q] = 1'b0;
            rev_d[idx_b_q] = 1'b0;
            miss_d         = 1'b1;
            state_d        = StFirst;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == StCompare) || (state_d == StShow);
    win_d  = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      arr_q   <= '0;
      rev_q   <= '0;
      idx_a_q <= '0;
      idx_b_q <= '0;
      cnt_q   <= '0;
      pairs_q <= '0;
      match_q <= 1'b0;
      miss_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arr_q   <= arr_d;
      rev_q   <= rev_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      cnt_q   <= cnt_d;
      pairs_q <= pairs_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
    end
  end

  assign arr_out_o  = arr_q;
  assign revealed_o = rev_q;
  assign busy_o     = busy_q;
  assign match_p_o  = match_q;
  assign miss_p_o   = miss_q;
  assign sel_err_o  = err_q;
  assign pairs_o    = pairs_q;
  assign win_o      = win_q;

endmodule

// File: tb/tb_card_match_checker.sv
// Directed bench for card_match_checker with a short display interval (SHOW_CYCLES = 4).
module tb_card_match_checker;

  logic             clk;
  logic             rst_ni;
  logic             load;
  logic [15:0][4:0] arr_in;
  logic             sel_valid;
  logic [3:0]       sel_idx;
  logic [15:0][4:0] arr_out;
  logic [15:0]      revealed;
  logic             busy;
  logic             match_p;
  logic             miss_p;
  logic             sel_err;
  logic [3:0]       pairs;
  logic             win;

  int n_checks = 0;
  int n_errors = 0;

  card_match_checker #(.SHOW_CYCLES(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .load_i     (load),
    .arr_in_i   (arr_in),
    .sel_valid_i(sel_valid),
    .sel_idx_i  (sel_idx),
    .arr_out_o  (arr_out),
    .revealed_o (revealed),
    .busy_o     (busy),
    .match_p_o  (match_p),
    .miss_p_o   (miss_p),
    .sel_err_o  (sel_err),
    .pairs_o    (pairs),
    .win_o      (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Expected array: symbol i>>1 at position i, matched flag from the mask.
  function automatic logic [79:0] exp_arr(input logic [15:0] flags);
    logic [79:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*5 +: 5] = {flags[i], 4'(i >> 1)};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input int idx);
    sel_valid = 1'b1;
    sel_idx   = 4'(idx);
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    logic seen_miss;
    logic [15:0] flags;
    rst_ni    = 1'b0;
    load      = 1'b0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    // Odd positions carry a stray bit 4 that load must discard.
    for (int i = 0; i < 16; i++) arr_in[i] = 5'(((i & 1) << 4) | (i >> 1));

    tick();
    tick();
    chk("rst_arr", arr_out, '0);
    chk("rst_outs", {revealed, busy, match_p, miss_p, sel_err, pairs, win}, '0);
    rst_ni = 1'b1;
    tick();

    sel(3);
    chk("idle_sel", {revealed, sel_err, busy}, '0);

    do_load();
    chk("load_arr", arr_out, exp_arr(16'h0000));
    chk("load_pairs", {pairs, busy, win, revealed}, '0);

    // Match: positions 0 and 1 share symbol 0.
    sel(0);
    chk("first_rev", revealed, 16'h0001);
    chk("first_busy", {busy, sel_err}, 2'b00);
    sel(1);
    chk("cmp_rev", revealed, 16'h0003);
    chk("cmp_busy", {busy, match_p}, 2'b10);
    tick();
    chk("match_p", {match_p, busy, miss_p}, 3'b100);
    chk("match_arr", arr_out, exp_arr(16'h0003));
    chk("match_pairs", pairs, 4'd1);
    chk("match_rev", revealed, 16'h0000);
    tick();
    chk("match_pulse_end", match_p, 1'b0);

    sel(0);
    chk("rej_matched", {sel_err, revealed}, {1'b1, 16'h0000});

    // Mismatch: 2 (symbol 1) vs 4 (symbol 2).
    sel(2);
    chk("rej_clear", sel_err, 1'b0);
    sel(4);
    chk("mm_cmp", {revealed, busy, miss_p}, {16'h0014, 1'b1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        sel_valid = 1'b1;
        sel_idx   = 4'd6;
      end
      tick();
      sel_valid = 1'b0;
      chk($sformatf("mm_show%0d", k), {revealed, busy, miss_p, sel_err}, {16'h0014, 3'b100});
    end
    tick();
    chk("mm_miss", {miss_p, busy, revealed, sel_err}, {2'b10, 16'h0000, 1'b0});
    chk("mm_pairs", pairs, 4'd1);
    tick();
    chk("miss_pulse_end", miss_p, 1'b0);

    // Same card twice, then a matched card, in the second slot.
    sel(4);
    chk("sec_rev", revealed, 16'h0010);
    sel(4);
    chk("rej_same", {sel_err, revealed, busy}, {1'b1, 16'h0010, 1'b0});
    sel(1);
    chk("rej_sec_matched", {sel_err, revealed, busy}, {1'b1, 16'h0010, 1'b0});
    sel(5);
    chk("sec_ok", {revealed, busy, sel_err}, {16'h0030, 2'b10});
    tick();
    chk("match2", {match_p, pairs}, {1'b1, 4'd2});

    flags = 16'h0033;
    foreach (flags[i]) if (i < 0) flags[i] = 1'b0;
    for (int p = 1; p < 8; p++) begin
      if (p == 2) continue;
      sel(2 * p);
      sel(2 * p + 1);
      tick();
      flags[2*p]   = 1'b1;
      flags[2*p+1] = 1'b1;
      chk($sformatf("pair%0d", p), {match_p, revealed}, {1'b1, 16'h0000});
    end
    chk("win_pairs", pairs, 4'd8);
    chk("win_flag", {win, busy}, 2'b10);
    chk("win_arr", arr_out, exp_arr(flags));
    sel(0);
    chk("done_sel", {sel_err, revealed, win}, {1'b0, 16'h0000, 1'b1});
    tick();
    chk("done_quiet", {match_p, miss_p, sel_err, pairs}, {3'b000, 4'd8});

    do_load();
    chk("reload", {pairs, win}, '0);
    chk("reload_arr", arr_out, exp_arr(16'h0000));
    sel(0);
    chk("reload_first", revealed, 16'h0001);

    // load mid-SHOW aborts the turn without miss_p.
    sel(2);
    tick();
    chk("abort_show", {busy, revealed}, {1'b1, 16'h0005});
    do_load();
    chk("abort_load", {revealed, busy, miss_p}, '0);
    seen_miss = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen_miss |= miss_p;
    end
    chk("abort_nomiss", seen_miss, 1'b0);

    // load beats a simultaneous selection.
    load      = 1'b1;
    sel_valid = 1'b1;
    sel_idx   = 4'd3;
    tick();
    load      = 1'b0;
    sel_valid = 1'b0;
    chk("load_sel", {revealed, sel_err}, '0);
    sel(3);
    chk("after_load_sel", revealed, 16'h0008);

    // Async reset mid-SHOW.
    sel(5);
    tick();
    chk("rst_pre", {busy, revealed}, {1'b1, 16'h0028});
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_async_arr", arr_out, '0);
    chk("rst_async_outs", {revealed, busy, match_p, miss_p, sel_err, pairs, win}, '0);
    tick();
    rst_ni = 1'b1;
    sel(3);
    chk("rst_idle", {revealed, sel_err, busy}, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/card_match_checker.md
# card_match_checker

Pair-matching stage fed by the card controller's 16-entry shuffled card array. It latches the array on a load pulse and accepts two player selections per turn. It compares the two symbols, marks matched pairs permanently and holds a mismatched pair face-up for a fixed display interval before hiding it. It counts found pairs and flags the win condition for the game-level FSM and the display.

## Interface

Parameters:
- SHOW_CYCLES, default 50_000_000: cycles a mismatched pair stays revealed (1 s at 50 MHz).

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- load  in  1  single-cycle pulse: latch arr_in, clear all game state.
- arr_in  in  5×16  card words from the card controller; [3:0] symbol id (0–7), [4] ignored on load.
- sel_valid  in  1  single-cycle pulse: player selects the card at sel_idx.
- sel_idx  in  4  selected card position 0–15.
- arr_out  out  5×16  latched cards; [3:0] symbol, [4] matched flag.
- revealed  out  16  one bit per position currently face-up but not yet matched.
- busy  out  1  high in COMPARE and SHOW; selections are ignored.
- match_p  out  1  one-cycle pulse when a pair matches.
- miss_p  out  1  one-cycle pulse at the end of SHOW for a mismatch.
- sel_err  out  1  one-cycle pulse when a selection is rejected.
- pairs  out  4  matched pairs, 0–8.
- win  out  1  high in DONE.

## Operation

- States: IDLE, FIRST, SECOND, COMPARE, SHOW, DONE.
- IDLE: waits for load. sel_valid is ignored without sel_err.
- load, in any state:
  - arr_out[i] <= {1'b0, arr_in[i][3:0]}.
  - revealed, pairs and the SHOW counter are cleared.
  - Next state is FIRST.
  - load beats a simultaneous sel_valid; that selection is dropped.
- FIRST, on sel_valid:
  - If arr_out[sel_idx][4]=1, pulse sel_err and stay in FIRST.
  - Otherwise store idx_a, set revealed[sel_idx], go to SECOND.
- SECOND, on sel_valid:
  - If the card is matched or sel_idx==idx_a, pulse sel_err and stay in SECOND.
  - Otherwise store idx_b, set revealed[sel_idx], go to COMPARE.
- COMPARE (exactly 1 cycle), testing arr_out[idx_a][3:0]==arr_out[idx_b][3:0]:
  - Equal:
    - Set both [4] flags and clear both revealed bits.
    - pairs+1 and pulse match_p.
    - Go to DONE if the new pairs==8, else FIRST.
  - Unequal: load the counter with SHOW_CYCLES-1 and go to SHOW.
- SHOW:
  - The counter decrements each cycle.
  - At 0: clear both revealed bits, pulse miss_p, go to FIRST.
  - Both revealed bits are held throughout SHOW.
- DONE: win=1 and selections are ignored silently. Only load or rst leaves DONE.
- The counter width is $clog2(SHOW_CYCLES) with a minimum of 1 bit. SHOW_CYCLES=1 gives a 1-cycle SHOW.
- pairs saturates logically at 8; no wrap is possible because DONE blocks further matches.

## Timing

- Reset values: state IDLE; arr_out all 0; revealed=0; pairs=0; busy, match_p, miss_p, sel_err, win all 0.
- Reset is asynchronous. Assertion in any state, including mid-SHOW, returns everything to the reset values immediately.
- All outputs are registered.
- Selection latency:
  - The revealed bit and the state change appear 1 cycle after the sel_valid edge.
  - sel_err appears on the same 1-cycle-later edge, for one cycle.
- Match path: second sel_valid at cycle t → COMPARE at t+1 → match_p, arr_out flags and pairs update visible at t+2.
- Mismatch path: COMPARE at t+1 → SHOW for SHOW_CYCLES cycles → miss_p and revealed cleared at t+2+SHOW_CYCLES.
- busy is high for every cycle spent in COMPARE or SHOW.
- load latency: arr_out, pairs and state are valid 1 cycle after the load pulse.

## Test plan

- Reset/load: hold rst=0, check all outputs are 0. Release, pulse load with arr_in[i]=i>>1 → next cycle arr_out[i]=i>>1, state FIRST, pairs=0.
- Match: with SHOW_CYCLES=4, select 0 then 1 (both symbol 0) → match_p 2 cycles after the second select, arr_out[0][4]=arr_out[1][4]=1, pairs=1, revealed=0.
- Mismatch: select 0 then 2 → revealed=16'h0005 through COMPARE and the 4 SHOW cycles, busy=1. Then miss_p and revealed=0; a sel_valid during SHOW changes nothing.
- Rejections:
  - Select matched card 0 → sel_err, state FIRST.
  - Select 4 then 4 again → sel_err, revealed=16'h0010, still SECOND.
- Win: match all 8 pairs → pairs=8 and win=1 on the cycle after the 8th COMPARE. Further sel_valid gives no pulses; load returns to FIRST with pairs=0.
- Abort:
  - load asserted mid-SHOW → revealed=0, no miss_p.
  - rst asserted mid-SHOW → all outputs 0 asynchronously, before the next clk edge.
  - load and sel_valid in the same cycle → the selection is ignored.
